// File: rtl/qk_tile_sequencer_pkg.sv
// Shared definitions for the Q*K tile sequencer: FSM encoding, tile geometry,
// and the element packing helper used wherever a tile is built or unpacked.
package qk_tile_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CLEAR   = 4'd1,
    ST_FILL_A  = 4'd2,
    ST_FILL_B  = 4'd3,
    ST_ISSUE   = 4'd4,
    ST_DRAIN   = 4'd5,
    ST_COMPARE = 4'd6,
    ST_SAMPLE  = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int TILE_BITS = 32 * DEF_WIDTH;

  // Bit offset of element rc inside a packed 4x4 tile of 2*width-bit elements
  function automatic int elem_lsb(input int r, input int c, input int width);
    return (4 * r + c) * 2 * width;
  endfunction

endpackage

// File: rtl/qk_tile_sequencer_if.sv
// Valid/ready tile channel from the Q*K systolic array into the sequencer.
interface qk_tile_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                   tile_valid;
  logic [32*WIDTH-1:0]    tile_data;
  logic                   tile_ready;

  modport master (output tile_valid, output tile_data, input tile_ready);
  modport slave  (input tile_valid, input tile_data, output tile_ready);
endinterface

// File: rtl/qk_pair_register.sv
// Holding registers for the two tiles of a result pair; each loads on its own
// enable and otherwise holds, so the accumulator sees stable operands.
module qk_pair_register
  import qk_tile_sequencer_pkg::*;
#(
  parameter int TW = TILE_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load1,
  input  logic          load2,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] data1,
  output logic [TW-1:0] data2
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data1 <= '0;
      data2 <= '0;
    end else begin
      if (load1) data1 <= din;
      if (load2) data2 <= din;
    end
  end

endmodule

// File: rtl/qk_tile_sequencer.sv
// Pairs 4x4 Q*K result tiles for the head-pruning accumulator, sequences its
// clear/enable/compare strobes and collects the per-head prune decisions.
module qk_tile_sequencer
  import qk_tile_sequencer_pkg::*;
#(
  parameter int  WIDTH          = 8,
  parameter int  TILES_PER_HEAD = 32,
  parameter int  NUM_HEADS      = 4,
  localparam int HW             = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  qk_tile_sequencer_if.slave    tile,
  output logic                  pair_enable,
  output logic [32*WIDTH-1:0]   pair_data1,
  output logic [32*WIDTH-1:0]   pair_data2,
  output logic                  compare_flag,
  output logic                  mean_clear,
  input  logic                  prune_head,
  output logic [HW-1:0]         head_idx,
  output logic [NUM_HEADS-1:0]  prune_mask,
  output logic                  busy,
  output logic                  done
);

  localparam int PAIRS = TILES_PER_HEAD / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   pair_cnt;
  logic            pair_last, head_last;

  assign pair_last = (pair_cnt == CW'(PAIRS - 1));
  assign head_last = (head_idx == HW'(NUM_HEADS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // tile_ready is only high in the fill states, so valid alone decides the handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_FILL_A;
      ST_FILL_A:  if (tile.tile_valid) state_d = ST_FILL_B;
      ST_FILL_B:  if (tile.tile_valid) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = pair_last ? ST_DRAIN : ST_FILL_A;
      ST_DRAIN:   state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_SAMPLE;
      ST_SAMPLE:  state_d = head_last ? ST_DONE : ST_CLEAR;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tile.tile_ready = 1'b0;
    pair_enable     = 1'b0;
    compare_flag    = 1'b0;
    mean_clear      = 1'b0;
    done            = 1'b0;
    busy            = (state_q != ST_IDLE);
    case (state_q)
      ST_CLEAR:   mean_clear      = 1'b1;
      ST_FILL_A:  tile.tile_ready = 1'b1;
      ST_FILL_B:  tile.tile_ready = 1'b1;
      ST_ISSUE:   pair_enable     = 1'b1;
      ST_COMPARE: compare_flag    = 1'b1;
      ST_DONE:    done            = 1'b1;
      default:    ;
    endcase
  end

  // Pair/head counters and the prune mask advance only at the FSM hand-off points
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt   <= '0;
      head_idx   <= '0;
      prune_mask <= '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) prune_mask <= '0;
        ST_ISSUE:  pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
        ST_SAMPLE: begin
          for (int h = 0; h < NUM_HEADS; h++)
            if (head_idx == HW'(h)) prune_mask[h] <= prune_head;
          if (!head_last) head_idx <= head_idx + 1'b1;
        end
        ST_DONE:   head_idx <= '0;
        default:   ;
      endcase
    end
  end

  qk_pair_register #(
    .TW (32 * WIDTH)
  ) u_pair_reg (
    .clk   (clk),
    .reset (reset),
    .load1 ((state_q == ST_FILL_A) && tile.tile_valid),
    .load2 ((state_q == ST_FILL_B) && tile.tile_valid),
    .din   (tile.tile_data),
    .data1 (pair_data1),
    .data2 (pair_data2)
  );

endmodule

// File: tb/tb_qk_tile_sequencer.sv
// Directed bench for qk_tile_sequencer: a cycle table on a 2-tile/1-head
// instance plus multi-head runs, backpressure and mid-run reset on the default one.
module tb_qk_tile_sequencer;
  import qk_tile_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance: 32 tiles/head, 4 heads
  qk_tile_sequencer_if #(.WIDTH(8)) tif_d ();
  logic                 d_start, d_prune, d_pe, d_cmp, d_clr, d_busy, d_done;
  logic [TILE_BITS-1:0] d_data1, d_data2;
  logic [1:0]           d_head;
  logic [3:0]           d_mask;

  qk_tile_sequencer #(.WIDTH(8), .TILES_PER_HEAD(32), .NUM_HEADS(4)) dut_d (
    .clk(clk), .reset(reset), .start(d_start), .tile(tif_d),
    .pair_enable(d_pe), .pair_data1(d_data1), .pair_data2(d_data2),
    .compare_flag(d_cmp), .mean_clear(d_clr), .prune_head(d_prune),
    .head_idx(d_head), .prune_mask(d_mask), .busy(d_busy), .done(d_done)
  );

  // Small instance: 2 tiles/head, 1 head, prune_head tied high
  qk_tile_sequencer_if #(.WIDTH(8)) tif_s ();
  logic                 s_start, s_prune, s_pe, s_cmp, s_clr, s_busy, s_done;
  logic [TILE_BITS-1:0] s_data1, s_data2;
  logic [0:0]           s_head;
  logic [0:0]           s_mask;

  qk_tile_sequencer #(.WIDTH(8), .TILES_PER_HEAD(2), .NUM_HEADS(1)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .tile(tif_s),
    .pair_enable(s_pe), .pair_data1(s_data1), .pair_data2(s_data2),
    .compare_flag(s_cmp), .mean_clear(s_clr), .prune_head(s_prune),
    .head_idx(s_head), .prune_mask(s_mask), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] din;
    logic [6:0]  ctrl;   // {ready, pair_enable, mean_clear, compare, busy, done, mask}
    logic [15:0] d1;
    logic [15:0] d2;
  } vec_t;

  vec_t tbl[11];

  // Run-level bookkeeping shared by do_run and the checks after it
  int n_pe, n_clr, n_done, tx, rx;
  int pe_h[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TILE_BITS-1:0] mk_tile(input int idx);
    logic [TILE_BITS-1:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[elem_lsb(r, c, 8) +: 16] = 16'(((4 * r + c) << 12) | (idx & 12'hFFF));
    return t;
  endfunction

  task automatic do_run(input bit bp, input bit start_h1, input int abort_at,
                        input logic [3:0] pat, input string tag);
    bit fin, aborted, pulsed;
    fin = 0; aborted = 0; pulsed = 0;
    n_pe = 0; n_clr = 0; n_done = 0; tx = 0; rx = 0;
    for (int h = 0; h < 4; h++) pe_h[h] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (abort_at > 0 && tx == abort_at) begin
        aborted = 1;
        break;
      end
      if (d_pe) begin
        chk($sformatf("%s pair%0d data1", tag, rx), d_data1, mk_tile(2 * rx));
        chk($sformatf("%s pair%0d data2", tag, rx), d_data2, mk_tile(2 * rx + 1));
        rx++; n_pe++; pe_h[d_head]++;
      end
      if (d_clr)  n_clr++;
      if (d_done) begin n_done++; fin = 1; end
      d_start = 1'b0;
      if (cyc == 0) d_start = 1'b1;
      else if (start_h1 && d_head == 2'd1 && !pulsed) begin
        d_start = 1'b1;
        pulsed  = 1;
      end
      d_prune = pat[d_head];
      tif_d.tile_valid = fin ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      tif_d.tile_data  = mk_tile(tx);
      if (tif_d.tile_valid && tif_d.tile_ready) tx++;
      if (fin) break;
    end
    chk({tag, " run ended"}, 1'(fin | aborted), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    void'($urandom(32'd1234));
    tbl[0]  = '{1'b1, 1'b1, 16'h0001, 7'b0000000, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0001, 7'b0010100, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0001, 7'b1000100, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'hFFFF, 7'b1000100, 16'h0001, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 16'h5555, 7'b0100100, 16'h0001, 16'hFFFF};
    tbl[5]  = '{1'b0, 1'b1, 16'h5555, 7'b0000100, 16'h0001, 16'hFFFF};
    tbl[6]  = '{1'b0, 1'b0, 16'h5555, 7'b0001100, 16'h0001, 16'hFFFF};
    tbl[7]  = '{1'b1, 1'b0, 16'h5555, 7'b0000100, 16'h0001, 16'hFFFF};
    tbl[8]  = '{1'b0, 1'b0, 16'h5555, 7'b0000111, 16'h0001, 16'hFFFF};
    tbl[9]  = '{1'b0, 1'b0, 16'h5555, 7'b0000001, 16'h0001, 16'hFFFF};
    tbl[10] = '{1'b0, 1'b0, 16'h5555, 7'b0000001, 16'h0001, 16'hFFFF};

    reset = 1'b1;
    d_start = 1'b0; d_prune = 1'b0; tif_d.tile_valid = 1'b0; tif_d.tile_data = '0;
    s_start = 1'b0; s_prune = 1'b1; tif_s.tile_valid = 1'b0; tif_s.tile_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tif_d.tile_valid = 1'b1;
    tif_d.tile_data  = mk_tile(99);

    // Reset state, then idle with valid held: nothing may be accepted
    @(negedge clk);
    chk("rst ctrl", {tif_d.tile_ready, d_pe, d_clr, d_cmp, d_busy, d_done}, 6'b0);
    chk("rst head", d_head, 2'd0);
    chk("rst mask", d_mask, 4'd0);
    chk("rst data1", d_data1, '0);
    chk("rst data2", d_data2, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle ready c%0d", i), {tif_d.tile_ready, d_busy}, 2'b00);
    end
    chk("idle data1 untouched", d_data1, '0);
    tif_d.tile_valid = 1'b0;

    // Cycle table on the small instance: outputs observed, then inputs applied
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("s%0d ctrl", i),
          {tif_s.tile_ready, s_pe, s_clr, s_cmp, s_busy, s_done, s_mask}, tbl[i].ctrl);
      chk($sformatf("s%0d data1", i), s_data1, {16{tbl[i].d1}});
      chk($sformatf("s%0d data2", i), s_data2, {16{tbl[i].d2}});
      s_start          = tbl[i].start;
      tif_s.tile_valid = tbl[i].valid;
      tif_s.tile_data  = {16{tbl[i].din}};
    end
    s_start = 1'b0;
    tif_s.tile_valid = 1'b0;

    // Full default run, no backpressure, heads 1 and 3 pruned
    do_run(1'b0, 1'b0, 0, 4'b1010, "run1");
    chk("run1 mask", d_mask, 4'b1010);
    chk("run1 done count", n_done, 1);
    chk("run1 clear count", n_clr, 4);
    for (int h = 0; h < 4; h++) chk($sformatf("run1 pairs head%0d", h), pe_h[h], 16);

    // Random backpressure with a stray start during head 1
    do_run(1'b1, 1'b1, 0, 4'b0110, "run2");
    chk("run2 mask", d_mask, 4'b0110);
    chk("run2 done count", n_done, 1);
    chk("run2 head count", n_clr, 4);
    chk("run2 pair count", n_pe, 64);
    chk("run2 tiles accepted", tx, 128);

    // Reset in FILL_B of head 2 (65 tiles accepted), start asserted alongside
    do_run(1'b0, 1'b0, 65, 4'b1111, "run3");
    chk("abort in fill_b", {tif_d.tile_ready, d_head}, 3'b110);
    chk("abort mask so far", d_mask, 4'b0011);
    reset = 1'b1;
    d_start = 1'b1;
    tif_d.tile_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d_start = 1'b0;
    tif_d.tile_valid = 1'b0;
    chk("post-reset busy", {d_busy, tif_d.tile_ready}, 2'b00);
    chk("post-reset mask", d_mask, 4'd0);
    chk("post-reset head", d_head, 2'd0);
    chk("post-reset data1", d_data1, '0);
    chk("post-reset data2", d_data2, '0);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (d_done) n_done++;
    end
    chk("post-reset no done", n_done, 0);

    do_run(1'b0, 1'b0, 0, 4'b1010, "run4");
    chk("run4 mask", d_mask, 4'b1010);
    chk("run4 done count", n_done, 1);
    chk("run4 pair count", n_pe, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
